// File: rtl/rv32i_writeback.sv
// RV32I writeback stage: selects ALU/CSR result or extracted load data and
// drives a registered single-cycle write into the base register file.
module rv32i_writeback (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_ce,
   input  logic        i_flush,
   input  logic        i_wr_rd,
   input  logic        i_is_load,
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_addr_lo,
   input  logic [4:0]  i_rd_addr,
   input  logic [31:0] i_result,
   input  logic [31:0] i_load_data,
   input  logic        i_ack,
   output logic        o_wr,
   output logic [4:0]  o_rd_addr,
   output logic [31:0] o_rd,
   output logic        o_stall
);

   typedef enum logic {IDLE, WAIT_LOAD} state_t;

   state_t      r_state, w_nxt_state;
   logic [2:0]  r_funct3;
   logic [1:0]  r_addr_lo;
   logic [4:0]  r_rd_addr;
   logic        r_wr_rd;

   logic        w_nxt_wr;
   logic [4:0]  w_nxt_rd_addr;
   logic [31:0] w_nxt_rd;
   logic        w_cap;
   logic        w_stall;
   logic [2:0]  w_f3;
   logic [1:0]  w_alo;
   logic [31:0] w_ext;

   function automatic logic [31:0] extract(input logic [31:0] d, input logic [2:0] f3,
                                           input logic [1:0] alo);
      logic [7:0]  b;
      logic [15:0] h;
      b = d[8*alo +: 8];
      h = alo[1] ? d[31:16] : d[15:0];
      case (f3)
         3'b000:  extract = {{24{b[7]}}, b};
         3'b100:  extract = {24'd0, b};
         3'b001:  extract = {{16{h[15]}}, h};
         3'b101:  extract = {16'd0, h};
         default: extract = d;
      endcase
   endfunction

   // A pending load is decoded with the fields captured when it was issued.
   assign w_f3  = (r_state == WAIT_LOAD) ? r_funct3  : i_funct3;
   assign w_alo = (r_state == WAIT_LOAD) ? r_addr_lo : i_addr_lo;
   assign w_ext = extract(i_load_data, w_f3, w_alo);

   always_comb begin
      w_nxt_state   = r_state;
      w_nxt_wr      = 1'b0;
      w_nxt_rd      = o_rd;
      w_nxt_rd_addr = o_rd_addr;
      w_cap         = 1'b0;
      w_stall       = 1'b0;
      if (i_flush) begin
         w_nxt_state = IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               if (i_ce) begin
                  if (i_is_load && !i_ack) begin
                     w_cap       = 1'b1;
                     w_stall     = 1'b1;
                     w_nxt_state = WAIT_LOAD;
                  end else begin
                     w_nxt_wr      = i_wr_rd && (i_rd_addr != 5'd0);
                     w_nxt_rd      = i_is_load ? w_ext : i_result;
                     w_nxt_rd_addr = i_rd_addr;
                  end
               end
            end
            WAIT_LOAD: begin
               if (i_ack) begin
                  w_nxt_wr      = r_wr_rd && (r_rd_addr != 5'd0);
                  w_nxt_rd      = w_ext;
                  w_nxt_rd_addr = r_rd_addr;
                  w_nxt_state   = IDLE;
               end else begin
                  w_stall = 1'b1;
               end
            end
            default: w_nxt_state = IDLE;
         endcase
      end
   end

   assign o_stall = w_stall;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= IDLE;
         r_funct3  <= 3'd0;
         r_addr_lo <= 2'd0;
         r_rd_addr <= 5'd0;
         r_wr_rd   <= 1'b0;
         o_wr      <= 1'b0;
         o_rd_addr <= 5'd0;
         o_rd      <= 32'd0;
      end else begin
         r_state   <= w_nxt_state;
         o_wr      <= w_nxt_wr;
         o_rd_addr <= w_nxt_rd_addr;
         o_rd      <= w_nxt_rd;
         if (w_cap) begin
            r_funct3  <= i_funct3;
            r_addr_lo <= i_addr_lo;
            r_rd_addr <= i_rd_addr;
            r_wr_rd   <= i_wr_rd;
         end
      end
   end

endmodule

// File: tb/tb_rv32i_writeback.sv
// Directed self-checking bench for rv32i_writeback.
module tb_rv32i_writeback;

   logic        i_clk = 1'b0;
   logic        i_rst, i_ce, i_flush, i_wr_rd, i_is_load, i_ack;
   logic [2:0]  i_funct3;
   logic [1:0]  i_addr_lo;
   logic [4:0]  i_rd_addr;
   logic [31:0] i_result, i_load_data;
   logic        o_wr, o_stall;
   logic [4:0]  o_rd_addr;
   logic [31:0] o_rd;

   int checks = 0;
   int errors = 0;

   always #5 i_clk = ~i_clk;

   rv32i_writeback dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_ce(i_ce), .i_flush(i_flush),
      .i_wr_rd(i_wr_rd), .i_is_load(i_is_load), .i_funct3(i_funct3),
      .i_addr_lo(i_addr_lo), .i_rd_addr(i_rd_addr), .i_result(i_result),
      .i_load_data(i_load_data), .i_ack(i_ack), .o_wr(o_wr),
      .o_rd_addr(o_rd_addr), .o_rd(o_rd), .o_stall(o_stall)
   );

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic idle_inputs();
      i_ce = 0; i_flush = 0; i_wr_rd = 0; i_is_load = 0; i_ack = 0;
      i_funct3 = 0; i_addr_lo = 0; i_rd_addr = 0; i_result = 0; i_load_data = 0;
   endtask

   task automatic test_reset();
      i_rst = 1;
      idle_inputs();
      step(); step();
      i_rst = 0;
      #1;
      checks++; if (o_wr !== 1'b0) begin errors++; $display("FAIL reset_wr got %0b want 0", o_wr); end
      checks++; if (o_rd_addr !== 5'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", o_rd_addr); end
      checks++; if (o_rd !== 32'd0) begin errors++; $display("FAIL reset_rd got %h want 0", o_rd); end
      checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b want 0", o_stall); end
   endtask

   task automatic test_nonload();
      i_ce = 1; i_wr_rd = 1; i_rd_addr = 5; i_result = 32'hDEADBEEF;
      step();
      idle_inputs();
      checks++; if (o_wr !== 1'b1) begin errors++; $display("FAIL nonload_wr got %0b want 1", o_wr); end
      checks++; if (o_rd_addr !== 5'd5) begin errors++; $display("FAIL nonload_addr got %0d want 5", o_rd_addr); end
      checks++; if (o_rd !== 32'hDEADBEEF) begin errors++; $display("FAIL nonload_rd got %h want deadbeef", o_rd); end
      step();
      checks++; if (o_wr !== 1'b0) begin errors++; $display("FAIL nonload_pulse got %0b want 0", o_wr); end
      checks++; if (o_rd !== 32'hDEADBEEF) begin errors++; $display("FAIL nonload_hold got %h want deadbeef", o_rd); end
   endtask

   task automatic test_load_extract();
      logic [2:0]  f3  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
      logic [1:0]  alo [5] = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd2};
      logic [31:0] exp [5] = '{32'hFFFFFF80, 32'h0000007F, 32'hFFFF80FF, 32'h00007F01, 32'h80FF7F01};
      for (int k = 0; k < 5; k++) begin
         i_ce = 1; i_is_load = 1; i_ack = 1; i_wr_rd = 1; i_load_data = 32'h80FF7F01;
         i_funct3 = f3[k]; i_addr_lo = alo[k]; i_rd_addr = 5'(10 + k); i_result = 32'h55555555;
         #1;
         checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL ld%0d_stall got %0b want 0", k, o_stall); end
         step();
         checks++; if (o_wr !== 1'b1 || o_rd !== exp[k] || o_rd_addr !== 5'(10 + k)) begin
            errors++; $display("FAIL ld%0d_data got wr=%0b rd=%h addr=%0d want wr=1 rd=%h addr=%0d",
                               k, o_wr, o_rd, o_rd_addr, exp[k], 10 + k);
         end
      end
      idle_inputs();
      step();
   endtask

   task automatic test_late_load();
      int wr_count = 0;
      i_ce = 1; i_is_load = 1; i_wr_rd = 1; i_funct3 = 3'b010; i_rd_addr = 9; i_ack = 0;
      i_load_data = 32'hBADBADBA;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++; if (o_stall !== 1'b1) begin errors++; $display("FAIL late_stall%0d got %0b want 1", c, o_stall); end
         step();
         if (o_wr === 1'b1) wr_count++;
         // ce pulses from upstream during the wait must be ignored
         i_ce = 1; i_is_load = 0; i_rd_addr = 3; i_result = 32'h0BADF00D; i_funct3 = 3'b000;
      end
      i_ack = 1; i_load_data = 32'h11223344;
      #1;
      checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL late_stall_ack got %0b want 0", o_stall); end
      step();
      if (o_wr === 1'b1) wr_count++;
      checks++; if (o_wr !== 1'b1 || o_rd_addr !== 5'd9 || o_rd !== 32'h11223344) begin
         errors++; $display("FAIL late_write got wr=%0b addr=%0d rd=%h want wr=1 addr=9 rd=11223344", o_wr, o_rd_addr, o_rd);
      end
      idle_inputs();
      step();
      if (o_wr === 1'b1) wr_count++;
      checks++; if (wr_count != 1) begin errors++; $display("FAIL late_wr_count got %0d want 1", wr_count); end
   endtask

   task automatic test_back_to_back();
      for (int k = 1; k <= 3; k++) begin
         i_ce = 1; i_wr_rd = 1; i_rd_addr = 5'(k); i_result = 32'(k * 32'h01010101);
         step();
         checks++; if (o_wr !== 1'b1 || o_rd_addr !== 5'(k) || o_rd !== 32'(k * 32'h01010101)) begin
            errors++; $display("FAIL b2b%0d got wr=%0b addr=%0d rd=%h want wr=1 addr=%0d rd=%h",
                               k, o_wr, o_rd_addr, o_rd, k, k * 32'h01010101);
         end
      end
      idle_inputs();
      step();
   endtask

   task automatic test_rd0();
      i_ce = 1; i_wr_rd = 1; i_rd_addr = 0; i_result = 32'h1234;
      step();
      idle_inputs();
      checks++; if (o_wr !== 1'b0) begin errors++; $display("FAIL rd0_wr got %0b want 0", o_wr); end
      checks++; if (o_rd !== 32'h1234 || o_rd_addr !== 5'd0) begin
         errors++; $display("FAIL rd0_update got rd=%h addr=%0d want rd=1234 addr=0", o_rd, o_rd_addr);
      end
      step();
   endtask

   task automatic test_flush();
      i_ce = 1; i_is_load = 1; i_wr_rd = 1; i_rd_addr = 7; i_funct3 = 3'b010;
      step();
      idle_inputs();
      i_flush = 1; i_ack = 1; i_load_data = 32'hCAFEF00D;
      #1;
      checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL flush_stall got %0b want 0", o_stall); end
      step();
      checks++; if (o_wr !== 1'b0) begin errors++; $display("FAIL flush_wr got %0b want 0", o_wr); end
      // An ack now must be ignored since nothing is pending.
      i_flush = 0; i_ack = 1;
      #1;
      checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL flush_idle_stall got %0b want 0", o_stall); end
      step();
      checks++; if (o_wr !== 1'b0) begin errors++; $display("FAIL flush_stray_ack got %0b want 0", o_wr); end
      idle_inputs();
      i_ce = 1; i_wr_rd = 1; i_rd_addr = 4; i_result = 32'hA5A5A5A5;
      step();
      idle_inputs();
      checks++; if (o_wr !== 1'b1 || o_rd !== 32'hA5A5A5A5) begin
         errors++; $display("FAIL flush_resume got wr=%0b rd=%h want wr=1 rd=a5a5a5a5", o_wr, o_rd);
      end
   endtask

   task automatic test_reset_pending();
      i_ce = 1; i_is_load = 1; i_wr_rd = 1; i_rd_addr = 12; i_funct3 = 3'b010;
      step();
      idle_inputs();
      i_rst = 1; i_ack = 1; i_load_data = 32'h77777777;
      step();
      i_rst = 0; i_ack = 0;
      #1;
      checks++; if (o_wr !== 1'b0 || o_rd_addr !== 5'd0 || o_rd !== 32'd0) begin
         errors++; $display("FAIL rstpend_out got wr=%0b addr=%0d rd=%h want all 0", o_wr, o_rd_addr, o_rd);
      end
      checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL rstpend_stall got %0b want 0", o_stall); end
      i_ack = 1; i_load_data = 32'h66666666;
      step();
      checks++; if (o_wr !== 1'b0) begin errors++; $display("FAIL rstpend_ack got %0b want 0", o_wr); end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_nonload();
      test_load_extract();
      test_late_load();
      test_back_to_back();
      test_rd0();
      test_flush();
      test_reset_pending();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
